// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding word reads to
// instruction memory and queues returned words in a small prefetch buffer.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_data,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        instr_valid,
   input  logic        instr_ready
);

   // state | meaning
   // IDLE  | no request; waiting for buffer room
   // BUSY  | request to pc outstanding
   // DROP  | stale request outstanding after a redirect; its data is discarded

   localparam int              AW      = $clog2(DEPTH);
   localparam int              CW      = AW + 1;
   localparam logic [31:0]     PC_MASK = 32'hFFFF_FFFC;
   localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);

   typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DROP} state_t;

   state_t        state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic [31:0]   stale_q, stale_d;
   logic [31:0]   data_q [DEPTH];
   logic [31:0]   data_d [DEPTH];
   logic [31:0]   tag_q [DEPTH];
   logic [31:0]   tag_d [DEPTH];
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [31:0]   instr_q, instr_d;
   logic [31:0]   instr_pc_q, instr_pc_d;

   logic          pop;
   logic          push;
   logic          ack_busy;
   logic          space;
   logic [CW-1:0] count_after_pop;
   logic [AW-1:0] rd_ptr_adv;

   always_comb begin
      pop             = (count_q != '0) && instr_ready;
      ack_busy        = (state_q == ST_BUSY) && imem_ack;
      push            = ack_busy && !redirect;
      count_after_pop = count_q - CW'(pop);
      space           = (count_after_pop + CW'(ack_busy)) < DEPTH_C;
      rd_ptr_adv      = rd_ptr_q + AW'(pop);

      state_d    = state_q;
      pc_d       = pc_q;
      stale_d    = stale_q;
      data_d     = data_q;
      tag_d      = tag_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;

      if (redirect) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
         pc_d     = redirect_pc & PC_MASK;
      end else begin
         rd_ptr_d = rd_ptr_adv;
         count_d  = count_after_pop + CW'(push);
         if (push) begin
            data_d[wr_ptr_q] = imem_data;
            tag_d[wr_ptr_q]  = pc_q;
            wr_ptr_d         = wr_ptr_q + AW'(1);
         end
         // Output registers track the head; an empty buffer leaves them holding.
         if (count_after_pop != '0) begin
            instr_d    = data_q[rd_ptr_adv];
            instr_pc_d = tag_q[rd_ptr_adv];
         end else if (push) begin
            instr_d    = imem_data;
            instr_pc_d = pc_q;
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (redirect || (count_after_pop < DEPTH_C)) state_d = ST_BUSY;
         end
         ST_BUSY: begin
            if (redirect) begin
               if (!imem_ack) begin
                  state_d = ST_DROP;
                  stale_d = pc_q;
               end
            end else if (imem_ack) begin
               pc_d = pc_q + 32'd4;
               if (!space) state_d = ST_IDLE;
            end
         end
         ST_DROP: begin
            if (imem_ack) state_d = ST_BUSY;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         pc_q       <= RESET_PC & PC_MASK;
         stale_q    <= RESET_PC & PC_MASK;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         instr_q    <= '0;
         instr_pc_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= '0;
            tag_q[i]  <= '0;
         end
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         stale_q    <= stale_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         instr_q    <= instr_d;
         instr_pc_q <= instr_pc_d;
         data_q     <= data_d;
         tag_q      <= tag_d;
      end
   end

   assign imem_req    = (state_q != ST_IDLE);
   assign imem_addr   = (state_q == ST_DROP) ? stale_q : pc_q;
   assign instr       = instr_q;
   assign instr_pc    = instr_pc_q;
   assign instr_valid = (count_q != '0);

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the single-cycle datapath. It owns the program counter and issues word reads to instruction memory over a req/ack handshake.
- Fetched words go into a small prefetch buffer. The buffer presents them to the datapath's 32-bit instruction input with a valid/ready handshake, tagged with their PC.
- A redirect input (branch/jump target from downstream) flushes the buffer and restarts fetch at the new PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- DEPTH, 2, prefetch buffer entries; power of two, at least 2.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  read request to instruction memory.
- imem_addr  out  32  byte address of the requested word.
- imem_ack  in  1  memory accepts and returns the word this cycle.
- imem_data  in  32  returned instruction word, valid when imem_ack=1.
- redirect  in  1  one-cycle pulse: flush and restart at redirect_pc.
- redirect_pc  in  32  new fetch address; bits [1:0] ignored and forced to 0.
- instr  out  32  instruction at buffer head, toward the datapath.
- instr_pc  out  32  PC of instr.
- instr_valid  out  1  buffer non-empty.
- instr_ready  in  1  datapath consumes the head this cycle.

Behaviour:
- Reset (async, immediate):
  - pc=RESET_PC, buffer empty, state=IDLE.
  - imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
- Memory handshake:
  - imem_req is held high and imem_addr held stable until an edge at which imem_ack=1.
  - Exactly one request is outstanding at a time.
  - imem_ack while imem_req=0 is ignored.
- Pop: the head is consumed at an edge with instr_valid=1 and instr_ready=1.
- Push: at an edge with imem_ack=1 in BUSY, imem_data and imem_addr are written at the tail.
- space: count - pop + push < DEPTH, evaluated on the current cycle's events.
- States:
  - IDLE: imem_req=0. Moves to BUSY at the next edge if count - pop < DEPTH, with imem_addr=pc.
  - BUSY: imem_req=1, imem_addr=pc.
    - On ack: push, pc<=pc+4.
    - Stay BUSY (back-to-back request at the new pc) if space, else go to IDLE.
    - Without ack: hold.
  - DROP: imem_req=1, imem_addr held at the stale address.
    - On ack: data discarded, pc unchanged (already the redirect target), go to BUSY.
- Redirect (priority over pop, push and ack):
  - Buffer emptied at that edge; pc<=redirect_pc.
  - From BUSY without ack: go to DROP.
  - From BUSY with ack the same cycle: data discarded, go to BUSY at redirect_pc.
  - From IDLE or DROP: go to BUSY (DROP with ack) or stay DROP (DROP without ack).
  - instr_valid=0 the cycle after a redirect.
- PC arithmetic: 32-bit modulo, so 32'hFFFF_FFFC+4 = 32'h0000_0000. pc[1:0] is always 0.
- Outputs:
  - instr, instr_pc and instr_valid come from registered buffer storage; there is no combinational path from imem_data to instr.
  - With an empty buffer, instr and instr_pc hold their last values; consumers qualify them with instr_valid.
- Latency and throughput:
  - Word acked at edge N appears on instr at cycle N+1.
  - With zero-wait memory (ack in the same cycle as req) and instr_ready=1, throughput is one instruction per cycle.
- Buffer boundaries:
  - Pop and push in the same cycle when full: legal, count unchanged.
  - Pop when empty: no effect.
  - Buffer pointers wrap modulo DEPTH.
- Reset mid-transaction: the outstanding request is abandoned. A late imem_ack after reset is ignored because state is IDLE with imem_req=0.

Test Plan:
- Reset release, imem_ack tied 1, instr_ready=1 -> imem_req rises with imem_addr=0, 4, 8… on consecutive cycles. instr_valid=1 from the second cycle with instr_pc=0, 4, 8…, one per cycle.
- instr_ready=0, zero-wait memory -> exactly DEPTH=2 words buffered (pc 0, 4), then imem_req=0 and instr_pc holds 0. Raise instr_ready -> fetch resumes at 8, with no word lost or duplicated.
- Memory acks 3 cycles after req -> imem_addr stable and imem_req high for all 3 cycles. instr_valid appears one cycle after each ack.
- redirect=1, redirect_pc=0x100, while a request to 0x8 is pending without ack -> state DROP. The later ack's data is not delivered; the next request is to 0x100; the first instr_pc after the redirect is 0x100.
- redirect coincident with ack and a non-empty buffer -> buffer flushed, the acked word dropped, instr_valid=0 next cycle, next imem_addr=redirect_pc.
- RESET_PC=32'hFFFF_FFFC, zero-wait memory -> instr_pc sequence FFFF_FFFC, 0000_0000, 0000_0004. Then assert rst mid-BUSY -> outputs clear immediately, and after release fetch restarts at FFFF_FFFC.
